// File: rtl/q32_comparator_core_if.sv
// ---------------------------------------------------------------------------
// q32_comparator_core_if
//
// Purpose: groups the operand, qualifier and result signals of the Q32.32
// threshold comparator so that the inference engine and the core share a
// single bundle.
//
// Signals:
//   feature    [63:0]  Q32.32 operand ([63:32] integer, [31:0] fraction)
//   threshold  [63:0]  Q32.32 node threshold, same format
//   in_valid           qualifies feature/threshold for the registered path
//   go_left            combinational feature <= threshold
//   out_valid          registered copy of in_valid
//   go_left_q          registered feature <= threshold
//   lt_q / eq_q / gt_q registered relational flags
//
// Modports:
//   master  - the engine side: drives operands, observes results
//   slave   - the comparator core: observes operands, drives results
// ---------------------------------------------------------------------------
interface q32_comparator_core_if;
  logic [63:0] feature;
  logic [63:0] threshold;
  logic        in_valid;
  logic        go_left;
  logic        out_valid;
  logic        go_left_q;
  logic        lt_q;
  logic        eq_q;
  logic        gt_q;

  modport master (
    output feature,
    output threshold,
    output in_valid,
    input  go_left,
    input  out_valid,
    input  go_left_q,
    input  lt_q,
    input  eq_q,
    input  gt_q
  );

  modport slave (
    input  feature,
    input  threshold,
    input  in_valid,
    output go_left,
    output out_valid,
    output go_left_q,
    output lt_q,
    output eq_q,
    output gt_q
  );
endinterface

// File: rtl/q32_comparator_core.sv
// ---------------------------------------------------------------------------
// q32_comparator_core
//
// Purpose: Q32.32 fixed-point threshold comparator for the decision-tree
// inference datapath. Decides whether traversal goes to the left child
// (feature <= threshold). A zero-latency combinational result feeds the
// engine's COMPARE state; a registered, valid-qualified copy with full
// relational flags serves pipelined or debug consumers.
//
// Parameters:
//   SIGNED  1: operands are two's-complement Q32.32
//           0: operands are unsigned 64-bit magnitudes
//
// Ports:
//   clk    rising-edge clock for the registered path
//   rst_n  asynchronous, active-low reset of the registered path only
//   cmp    slave side of q32_comparator_core_if
//            in : feature, threshold, in_valid
//            out: go_left (combinational), out_valid, go_left_q,
//                 lt_q, eq_q, gt_q (registered, 1-cycle latency)
// ---------------------------------------------------------------------------
module q32_comparator_core #(
  parameter bit SIGNED = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  q32_comparator_core_if.slave cmp
);

  // Operand halves: the integer word carries the sign, the fraction word is
  // always an unsigned magnitude.
  logic [31:0] featHi;
  logic [31:0] featLo;
  logic [31:0] thrHi;
  logic [31:0] thrLo;

  // High words re-keyed so that a plain unsigned compare yields the
  // required order for either SIGNED setting.
  logic [31:0] featHiKey;
  logic [31:0] thrHiKey;

  // Partial results of the two halves and the combined relation.
  logic hiLt;
  logic hiEq;
  logic loLt;
  logic loEq;
  logic ltNow;
  logic eqNow;
  logic gtNow;

  // Registered path state: next-state and current values.
  logic       valid_d;
  logic       valid_q;
  logic [3:0] flags_d;
  logic [3:0] flags_q;

  assign featHi = cmp.feature[63:32];
  assign featLo = cmp.feature[31:0];
  assign thrHi  = cmp.threshold[63:32];
  assign thrLo  = cmp.threshold[31:0];

  // Inverting the sign bit maps two's-complement order onto unsigned order,
  // so one magnitude comparator covers both SIGNED settings.
  assign featHiKey = {featHi[31] ^ SIGNED, featHi[30:0]};
  assign thrHiKey  = {thrHi[31] ^ SIGNED, thrHi[30:0]};

  // The single shared comparator: high words decide unless equal, in which
  // case the unsigned fraction compare breaks the tie. gt is derived so that
  // exactly one of lt/eq/gt is set for every input.
  always_comb begin
    hiLt  = (featHiKey < thrHiKey);
    hiEq  = (featHiKey == thrHiKey);
    loLt  = (featLo < thrLo);
    loEq  = (featLo == thrLo);
    ltNow = hiLt | (hiEq & loLt);
    eqNow = hiEq & loEq;
    gtNow = ~(ltNow | eqNow);
  end

  assign cmp.go_left = ltNow | eqNow;

  // Flags are packed as {go_left, lt, eq, gt}. They only reload when the
  // operands are qualified; otherwise the last result is held.
  always_comb begin
    valid_d = cmp.in_valid;
    flags_d = flags_q;
    if (cmp.in_valid) begin
      flags_d = {ltNow | eqNow, ltNow, eqNow, gtNow};
    end
  end

  // Asynchronous reset discards any compare in flight and wins over a
  // simultaneous in_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      flags_q <= 4'b0000;
    end else begin
      valid_q <= valid_d;
      flags_q <= flags_d;
    end
  end

  assign cmp.out_valid = valid_q;
  assign cmp.go_left_q = flags_q[3];
  assign cmp.lt_q      = flags_q[2];
  assign cmp.eq_q      = flags_q[1];
  assign cmp.gt_q      = flags_q[0];

endmodule

// File: tb/tb_q32_comparator_core.sv
// ---------------------------------------------------------------------------
// tb_q32_comparator_core
//
// Purpose: exercises a signed and an unsigned instance of the Q32.32
// comparator side by side with identical operands. A reference model based
// on native 64-bit signed/unsigned arithmetic predicts every output; a
// compare process checks both instances each cycle, and directed vectors
// pin hand-computed values.
// ---------------------------------------------------------------------------
module tb_q32_comparator_core;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] featureDrv;
  logic [63:0] thresholdDrv;
  logic        inValidDrv;

  int checks = 0;
  int errors = 0;
  bit cmpEn  = 1'b0;

  // Expected registered state: {go_left, lt, eq, gt} per instance.
  logic       expValid = 1'b0;
  logic [3:0] expS     = 4'b0000;
  logic [3:0] expU     = 4'b0000;

  q32_comparator_core_if ifS ();
  q32_comparator_core_if ifU ();

  assign ifS.feature   = featureDrv;
  assign ifS.threshold = thresholdDrv;
  assign ifS.in_valid  = inValidDrv;
  assign ifU.feature   = featureDrv;
  assign ifU.threshold = thresholdDrv;
  assign ifU.in_valid  = inValidDrv;

  q32_comparator_core #(.SIGNED(1'b1)) dutS (
    .clk   (clk),
    .rst_n (rst_n),
    .cmp   (ifS)
  );

  q32_comparator_core #(.SIGNED(1'b0)) dutU (
    .clk   (clk),
    .rst_n (rst_n),
    .cmp   (ifU)
  );

  always #5 clk = ~clk;

  // Reference relation {lt, eq, gt} from native 64-bit comparisons.
  function automatic logic [2:0] refCmp(input logic [63:0] f,
                                        input logic [63:0] t,
                                        input bit sgn);
    logic lt;
    logic eq;
    eq = (f == t);
    if (sgn) lt = ($signed(f) < $signed(t));
    else     lt = (f < t);
    return {lt, eq, ~lt & ~eq};
  endfunction

  function automatic logic [3:0] packFlags(input logic [2:0] r);
    return {r[2] | r[1], r};
  endfunction

  // Reference model of the registered path.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      expValid <= 1'b0;
      expS     <= 4'b0000;
      expU     <= 4'b0000;
    end else begin
      expValid <= inValidDrv;
      if (inValidDrv) begin
        expS <= packFlags(refCmp(featureDrv, thresholdDrv, 1'b1));
        expU <= packFlags(refCmp(featureDrv, thresholdDrv, 1'b0));
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, want, $time);
    end
  endtask

  // Registered outputs packed as {out_valid, go_left_q, lt_q, eq_q, gt_q}.
  task automatic checkRegs(input string tag, input logic [4:0] wantS,
                           input logic [4:0] wantU);
    checkOutput({tag, "_regS"},
                {ifS.out_valid, ifS.go_left_q, ifS.lt_q, ifS.eq_q, ifS.gt_q}, wantS);
    checkOutput({tag, "_regU"},
                {ifU.out_valid, ifU.go_left_q, ifU.lt_q, ifU.eq_q, ifU.gt_q}, wantU);
  endtask

  task automatic checkGoLeft(input string tag, input logic wantS, input logic wantU);
    checkOutput({tag, "_goLeftS"}, ifS.go_left, wantS);
    checkOutput({tag, "_goLeftU"}, ifU.go_left, wantU);
  endtask

  // Drives operands shortly after a rising edge so they are stable well
  // before the next edge samples them.
  task automatic applyStimulus(input logic [63:0] f, input logic [63:0] t,
                               input logic v);
    @(posedge clk);
    #2;
    featureDrv   = f;
    thresholdDrv = t;
    inValidDrv   = v;
  endtask

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    logic [2:0] rS;
    logic [2:0] rU;
    if (cmpEn) begin
      rS = refCmp(featureDrv, thresholdDrv, 1'b1);
      rU = refCmp(featureDrv, thresholdDrv, 1'b0);
      checkOutput("model_goLeftS", ifS.go_left, rS[2] | rS[1]);
      checkOutput("model_goLeftU", ifU.go_left, rU[2] | rU[1]);
      checkOutput("model_validS", ifS.out_valid, expValid);
      checkOutput("model_validU", ifU.out_valid, expValid);
      checkOutput("model_flagsS", {ifS.go_left_q, ifS.lt_q, ifS.eq_q, ifS.gt_q}, expS);
      checkOutput("model_flagsU", {ifU.go_left_q, ifU.lt_q, ifU.eq_q, ifU.gt_q}, expU);
      if (expValid) begin
        checkOutput("onehotS", $countones({ifS.lt_q, ifS.eq_q, ifS.gt_q}), 1);
        checkOutput("onehotU", $countones({ifU.lt_q, ifU.eq_q, ifU.gt_q}), 1);
      end
    end
  end

  initial begin
    logic [63:0] f;
    logic [63:0] t;

    rst_n        = 1'b1;
    featureDrv   = 64'd0;
    thresholdDrv = 64'd0;
    inValidDrv   = 1'b0;
    #1;
    rst_n = 1'b0;
    cmpEn = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    checkRegs("reset", 5'b00000, 5'b00000);
    #1;
    rst_n = 1'b1;

    // Equal operands, 1.5 == 1.5.
    applyStimulus(64'h0000_0001_8000_0000, 64'h0000_0001_8000_0000, 1'b1);
    #1 checkGoLeft("equal", 1'b1, 1'b1);
    @(posedge clk); #1;
    checkRegs("equal", 5'b11010, 5'b11010);

    // -1.0 against 1.5: sign decides only when SIGNED.
    applyStimulus(64'hFFFF_FFFF_0000_0000, 64'h0000_0001_8000_0000, 1'b1);
    #1 checkGoLeft("sign", 1'b1, 1'b0);
    @(posedge clk); #1;
    checkRegs("sign", 5'b11100, 5'b10001);

    // Fraction-only difference, both orders.
    applyStimulus(64'h0000_0002_0000_0001, 64'h0000_0002_0000_0000, 1'b1);
    #1 checkGoLeft("frac", 1'b0, 1'b0);
    @(posedge clk); #1;
    checkRegs("frac", 5'b10001, 5'b10001);
    applyStimulus(64'h0000_0002_0000_0000, 64'h0000_0002_0000_0001, 1'b1);
    #1 checkGoLeft("fracSwap", 1'b1, 1'b1);
    @(posedge clk); #1;
    checkRegs("fracSwap", 5'b11100, 5'b11100);

    // Most negative vs most positive, both orders.
    applyStimulus(64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1);
    #1 checkGoLeft("extreme", 1'b1, 1'b0);
    @(posedge clk); #1;
    checkRegs("extreme", 5'b11100, 5'b10001);
    applyStimulus(64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1'b1);
    #1 checkGoLeft("extremeSwap", 1'b0, 1'b1);
    @(posedge clk); #1;
    checkRegs("extremeSwap", 5'b10001, 5'b11100);

    // Dropping in_valid holds the flags and clears out_valid.
    applyStimulus(64'd0, 64'd1, 1'b0);
    #1 checkGoLeft("hold", 1'b1, 1'b1);
    @(posedge clk); #1;
    checkRegs("hold", 5'b00001, 5'b01100);

    // Asynchronous reset between edges while go_left keeps tracking.
    applyStimulus(64'd5, 64'd5, 1'b1);
    @(posedge clk); #1;
    checkRegs("preReset", 5'b11010, 5'b11010);
    rst_n      = 1'b0;
    featureDrv = 64'd9;
    #1;
    checkRegs("asyncReset", 5'b00000, 5'b00000);
    checkGoLeft("resetTrack0", 1'b0, 1'b0);
    featureDrv = 64'd2;
    #1 checkGoLeft("resetTrack1", 1'b1, 1'b1);
    @(posedge clk); #1;
    checkRegs("resetWins", 5'b00000, 5'b00000);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    checkRegs("postReset", 5'b11100, 5'b11100);

    // Random sweep biased toward equal and near-equal operand pairs.
    for (int i = 0; i < 10000; i++) begin
      f = {$urandom(), $urandom()};
      case ($urandom_range(0, 3))
        0:       t = f;
        1:       t = {f[63:32], $urandom()};
        2:       t = {$urandom(), $urandom()};
        default: t = f ^ (64'd1 << $urandom_range(0, 63));
      endcase
      applyStimulus(f, t, ($urandom_range(0, 7) != 0));
    end

    @(posedge clk);
    @(negedge clk);
    #1;
    cmpEn = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/q32_comparator_core.md
# q32_comparator_core

Q32.32 fixed-point threshold comparator for the decision-tree inference datapath. It compares a selected 64-bit feature against a node threshold and says whether traversal goes to the left child (`feature <= threshold`). A zero-latency combinational result feeds the engine's COMPARE state directly. A registered, valid-qualified copy with full relational flags is provided for pipelined or debug use.

## Interface
Parameters:
- `SIGNED`, default 1: 1 compares both operands as two's-complement Q32.32; 0 compares them as unsigned 64-bit.

Ports:
- `clk` input 1: clock, rising-edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `feature` input 64: Q32.32 operand. [63:32] is the integer part, [31:0] is the fraction.
- `threshold` input 64: Q32.32 node threshold, same format.
- `go_left` output 1: combinational, 1 when `feature <= threshold`.
- `in_valid` input 1: qualifies `feature` and `threshold` for the registered path.
- `out_valid` output 1: registered copy of `in_valid`.
- `go_left_q` output 1: registered `feature <= threshold`.
- `lt_q` output 1: registered `feature < threshold`.
- `eq_q` output 1: registered `feature == threshold`.
- `gt_q` output 1: registered `feature > threshold`.

## Operation
- Ordering rule:
  - With `SIGNED=1`, order is full 64-bit two's complement. Bit 63 is the sign. The fraction bits take part in the compare, so Q32.32 order equals integer order of the 64-bit word.
  - With `SIGNED=0`, order is plain unsigned 64-bit magnitude.
- Compare structure:
  - Compare the high words [63:32] first; this is a signed or unsigned compare per `SIGNED`.
  - If the high words are equal, the result is decided by an unsigned compare of the low words [31:0].
  - Derive `lt`, `eq`, `gt` from the two halves; exactly one is 1 at any time.
- Outputs:
  - `go_left = lt | eq`. It is purely combinational, with no dependence on `clk`, `rst_n` or `in_valid`.
  - The compare logic is shared between the combinational and registered paths; there is no second comparator.
- No X-propagation masking. Outputs are defined for every 64-bit input value; there are no NaN or saturation cases.

## Timing
- `go_left`: 0-cycle latency. It settles within the same cycle as the inputs. The engine samples it in the cycle its inputs are stable.
- Registered path, 1-cycle latency:
  - On each rising `clk`, `out_valid <= in_valid`.
  - If `in_valid=1`, `go_left_q`, `lt_q`, `eq_q`, `gt_q` load the current compare result.
  - If `in_valid=0`, the four flags hold their previous values; only `out_valid` drops.
- Back-to-back: `in_valid` may be high every cycle, giving one result per cycle. There is no stall or backpressure.
- Reset:
  - Asserting `rst_n=0` immediately clears `out_valid`, `go_left_q`, `lt_q`, `eq_q`, `gt_q` to 0, regardless of `clk`.
  - `go_left` is unaffected by reset and keeps tracking the inputs.
  - A compare in flight when reset asserts is discarded.
  - After `rst_n` deasserts, the first valid result appears on the first edge that samples `in_valid=1`.
- Simultaneous reset and `in_valid`: reset wins, and outputs stay 0.

## Test plan
- Equal operands: `feature=threshold=0x0000_0001_8000_0000` (1.5), `in_valid=1`.
  - Required: `go_left=1` in the same cycle.
  - Required, next edge: `eq_q=1`, `go_left_q=1`, `lt_q=0`, `gt_q=0`, `out_valid=1`.
- Sign handling: `feature=0xFFFF_FFFF_0000_0000` (-1.0), `threshold=0x0000_0001_8000_0000`.
  - `SIGNED=1`: `go_left=1`, `lt_q=1`.
  - `SIGNED=0`: `go_left=0`, `gt_q=1`.
- Fraction-only difference: `feature=0x0000_0002_0000_0001`, `threshold=0x0000_0002_0000_0000`.
  - Required: `go_left=0`, `gt_q=1`.
  - With the operands swapped: `go_left=1`, `lt_q=1`.
- Extremes with `SIGNED=1`: `feature=0x8000_0000_0000_0000`, `threshold=0x7FFF_FFFF_FFFF_FFFF`.
  - Required: `go_left=1`.
  - Swapped: `go_left=0`.
  - Random sweep of 10k pairs: every result matches a signed 64-bit reference model and exactly one flag is set.
- Hold and reset:
  - Load one result, then drop `in_valid`. Required: flags hold and `out_valid=0` on the next edge.
  - Assert `rst_n=0` between clock edges. Required: all registered outputs are 0 at once, while `go_left` keeps following the inputs.
